// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage and a DMA loader.
// Define DMEM_ARB_RR_EN for round-robin idle contention (default: CPU priority).
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_last,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        mem_memrw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_write,
  input  logic [31:0] mem_data_read
);

  typedef enum logic {
    IDLE,
    DMA_BURST
  } state_t;

  localparam logic [3:0] MAX = 4'(MAX_BURST);

  state_t     state, state_n;
  logic [3:0] beat, beat_n;
  logic       last_dma, last_dma_n;
  logic       cpu_gnt;
  logic       cpu_win;

  // A burst always ends with last_dma set, so both policies hand the
  // next idle contention to the CPU: that is the forced yield.
`ifdef DMEM_ARB_RR_EN
  assign cpu_win = cpu_req & (~dma_req | last_dma);
`else
  assign cpu_win = cpu_req;
`endif

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    last_dma_n = last_dma;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_win) begin
            cpu_gnt    = 1'b1;
            last_dma_n = 1'b0;
            beat_n     = 4'd0;
          end else if (dma_req) begin
            dma_gnt    = 1'b1;
            last_dma_n = 1'b1;
            if (dma_last || MAX == 4'd1) begin
              beat_n = 4'd0;
            end else begin
              beat_n  = 4'd1;
              state_n = DMA_BURST;
            end
          end
        end
        DMA_BURST: begin
          if (dma_req) begin
            dma_gnt = 1'b1;
            if (dma_last || (beat + 4'd1) >= MAX) begin
              state_n = IDLE;
              beat_n  = 4'd0;
            end else begin
              beat_n = beat + 4'd1;
            end
          end else begin
            state_n = IDLE;
            beat_n  = 4'd0;
          end
        end
        default: begin
          state_n = IDLE;
          beat_n  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= 4'd0;
      last_dma <= 1'b1;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      last_dma <= last_dma_n;
    end
  end

  assign mem_memrw = cpu_gnt ? cpu_we :
                     dma_gnt ? dma_we : 1'b0;
  assign mem_address = cpu_gnt ? cpu_addr :
                       dma_gnt ? dma_addr : 32'd0;
  assign mem_data_write = cpu_gnt ? cpu_wdata :
                          dma_gnt ? dma_wdata : 32'd0;

  assign cpu_rdata = mem_data_read;
  assign dma_rdata = mem_data_read;
  assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a single-cycle memory model.
// Expected grants follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_last;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt;
  logic        mem_memrw;
  logic [31:0] mem_address, mem_data_write, mem_data_read;

  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .mem_memrw(mem_memrw), .mem_address(mem_address),
    .mem_data_write(mem_data_write),
    .mem_data_read(mem_data_read)
  );

  assign mem_data_read = mem[mem_address[9:2]];

  always @(posedge clk)
    if (mem_memrw) mem[mem_address[9:2]] <= mem_data_write;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic cpu(input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma(input logic r, input logic w, input logic l,
                     input logic [31:0] a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_last = l;
    dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1;
    cpu(1, 1, 32'h10, 32'h1);
    dma(1, 1, 0, 32'h40, 32'h2);

    // reset: no grants, no writes, stall follows cpu_req
    cyc; settle;
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 0);
    chk("rst_memrw", {31'd0, mem_memrw}, 0);
    chk("rst_stall", {31'd0, cpu_stall}, 1);

    // CPU store then load
    cyc; rst = 1'b0;
    cpu(1, 1, 32'h10, 32'hA5A5A5A5);
    dma(0, 0, 0, 32'h0, 32'h0);
    settle;
    chk("st_stall", {31'd0, cpu_stall}, 0);
    chk("st_memrw", {31'd0, mem_memrw}, 1);
    chk("st_addr", mem_address, 32'h10);
    cyc; cpu(1, 0, 32'h10, 32'h0); settle;
    chk("ld_stall", {31'd0, cpu_stall}, 0);
    chk("ld_rdata", cpu_rdata, 32'hA5A5A5A5);

    // nobody requesting: port parked at zero
    cyc; cpu(0, 0, 32'h10, 32'hFFFF); settle;
    chk("idle_addr", mem_address, 32'h0);
    chk("idle_wdata", mem_data_write, 32'h0);
    chk("idle_dma_gnt", {31'd0, dma_gnt}, 0);

    // 6-beat DMA, cpu joins at beat 2, yield after beat 4
    cyc; dma(1, 1, 0, 32'h100, 32'hD0000001); settle;
    chk("b1_gnt", {31'd0, dma_gnt}, 1);
    cyc;
    dma(1, 1, 0, 32'h104, 32'hD0000002);
    cpu(1, 0, 32'h10, 32'h0);
    settle;
    chk("b2_gnt", {31'd0, dma_gnt}, 1);
    chk("b2_stall", {31'd0, cpu_stall}, 1);
    chk("b2_addr", mem_address, 32'h104);
    chk("b2_memrw", {31'd0, mem_memrw}, 1);
    cyc; dma(1, 1, 0, 32'h108, 32'hD0000003); settle;
    chk("b3_gnt", {31'd0, dma_gnt}, 1);
    chk("b3_stall", {31'd0, cpu_stall}, 1);
    cyc; dma(1, 1, 0, 32'h10C, 32'hD0000004); settle;
    chk("b4_gnt", {31'd0, dma_gnt}, 1);
    chk("b4_stall", {31'd0, cpu_stall}, 1);
    cyc; dma(1, 1, 0, 32'h110, 32'hD0000005); settle;
    chk("c5_dma_gnt", {31'd0, dma_gnt}, 0);
    chk("c5_stall", {31'd0, cpu_stall}, 0);
    chk("c5_rdata", cpu_rdata, 32'hA5A5A5A5);
    cyc; cpu(0, 0, 32'h0, 32'h0); settle;
    chk("c6_dma_gnt", {31'd0, dma_gnt}, 1);

    // DMA drops mid-burst: dead cycle, then CPU
    cyc;
    dma(0, 1, 0, 32'h114, 32'hD0000006);
    cpu(1, 0, 32'h108, 32'h0);
    settle;
    chk("drop_dma_gnt", {31'd0, dma_gnt}, 0);
    chk("drop_stall", {31'd0, cpu_stall}, 1);
    chk("drop_memrw", {31'd0, mem_memrw}, 0);
    cyc; settle;
    chk("drop_cpu", {31'd0, cpu_stall}, 0);
    chk("beat3_data", cpu_rdata, 32'hD0000003);

    // both requesting, single-beat DMA, from reset
    cyc; rst = 1'b1; cpu(0, 0, 32'h0, 32'h0); dma(0, 0, 0, 0, 0);
    cyc; rst = 1'b0;
    cpu(1, 0, 32'h10, 32'h0);
    dma(1, 0, 1, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      logic exp_dma;
`ifdef DMEM_ARB_RR_EN
      exp_dma = (i % 2) == 1;
`else
      exp_dma = 1'b0;
`endif
      if (i > 0) cyc;
      settle;
      chk($sformatf("cont%0d_dma", i), {31'd0, dma_gnt},
          {31'd0, exp_dma});
      chk($sformatf("cont%0d_stall", i), {31'd0, cpu_stall},
          {31'd0, exp_dma});
    end

    // reset at DMA beat 2 blocks the write
    cyc; cpu(0, 0, 32'h0, 32'h0);
    dma(1, 1, 0, 32'h200, 32'h11111111); settle;
    chk("rb1_gnt", {31'd0, dma_gnt}, 1);
    cyc; rst = 1'b1; dma(1, 1, 0, 32'h204, 32'h22222222); settle;
    chk("rb2_gnt", {31'd0, dma_gnt}, 0);
    chk("rb2_memrw", {31'd0, mem_memrw}, 0);
    cyc; rst = 1'b0;
    cpu(1, 0, 32'h204, 32'h0);
    dma(1, 1, 0, 32'h208, 32'h33333333);
    settle;
    chk("pr_stall", {31'd0, cpu_stall}, 0);
    chk("pr_dma_gnt", {31'd0, dma_gnt}, 0);
    chk("pr_rdata", cpu_rdata, 32'h0);

    cyc; cpu(0, 0, 32'h0, 32'h0); dma(0, 0, 0, 0, 0);
    cyc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
